vram_port_scheduler: RTL and testbench



---
 rtl/vram_port_scheduler_pkg.sv | 12 +
 rtl/vram_wr_fifo.sv | 52 +++++
 rtl/vram_port_scheduler.sv | 110 +++++++++++
 tb/tb_vram_port_scheduler.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_port_scheduler_pkg.sv
// Shared types for the VRAM port scheduler: FSM state encoding.
package vram_port_scheduler_pkg;

  // Bit 1 is the RAM output enable and bit 0 the write strobe, so the port
  // control pins come straight off the state register.
  typedef enum logic [1:0] {
    ST_BLANK_IDLE  = 2'b00,
    ST_BLANK_WRITE = 2'b01,
    ST_ACTIVE      = 2'b10
  } sched_state_t;

endpackage

// File: rtl/vram_wr_fifo.sv
// Synchronous write-request FIFO with wrap-bit pointers, full/empty and level.
module vram_wr_fifo #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int PTR_W = IDX_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty,
  output logic [PTR_W-1:0]  level
);

  logic [ADDR_W+DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]         wptr;
  logic [PTR_W-1:0]         rptr;
  logic                     do_push;
  logic                     do_pop;

  assign full    = (wptr[IDX_W] != rptr[IDX_W]) &&
                   (wptr[IDX_W-1:0] == rptr[IDX_W-1:0]);
  assign empty   = (wptr == rptr);
  assign level   = wptr - rptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign {head_addr, head_data} = mem[rptr[IDX_W-1:0]];

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[IDX_W-1:0]] <= {push_addr, push_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/vram_port_scheduler.sv
// Single-port line-RAM scheduler: video reads while active, queued control
// writes drained during blanking, with an optional per-interval write quota.
module vram_port_scheduler
  import vram_port_scheduler_pkg::*;
#(
  parameter int ADDR_W           = 4,
  parameter int DATA_W           = 8,
  parameter int FIFO_DEPTH       = 4,
  parameter int MAX_WR_PER_BLANK = 0,
  localparam int LVL_W           = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              I_clk,
  input  logic              I_rst,
  input  logic              I_wr_valid,
  input  logic [ADDR_W-1:0] I_wr_addr,
  input  logic [DATA_W-1:0] I_wr_data,
  output logic              O_wr_ready,
  input  logic              I_blanking,
  input  logic [ADDR_W-1:0] I_rd_addr,
  output logic              O_ram_oe,
  output logic              O_ram_wr,
  output logic [ADDR_W-1:0] O_ram_addr,
  output logic [DATA_W-1:0] O_ram_din,
  output logic [LVL_W-1:0]  O_level,
  output logic              O_busy
);

  localparam int CNT_W = (MAX_WR_PER_BLANK == 0) ? 1 : $clog2(MAX_WR_PER_BLANK + 1);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_WR_PER_BLANK);

  sched_state_t      state_p1;
  logic              blank_p1;
  logic [CNT_W-1:0]  wr_cnt_p1;
  logic [ADDR_W-1:0] ram_addr_p1;
  logic [DATA_W-1:0] ram_din_p1;

  logic              full;
  logic              empty;
  logic              push;
  logic              blank_rise;
  logic [CNT_W-1:0]  cnt_eff;
  logic              do_write;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  function automatic logic quota_open(input logic [CNT_W-1:0] cnt);
    return (MAX_WR_PER_BLANK == 0) || (cnt < MAX_C);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == '1) ? cnt : cnt + 1'b1;
  endfunction

  assign push       = I_wr_valid && !full;
  assign O_wr_ready = !full;
  assign O_busy     = !empty;

  // A new blanking interval sees a cleared count in the same cycle it starts.
  assign blank_rise = I_blanking && !blank_p1;
  assign cnt_eff    = blank_rise ? '0 : wr_cnt_p1;
  assign do_write   = I_blanking && !empty && quota_open(cnt_eff);

  vram_wr_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (I_clk),
    .rst       (I_rst),
    .push      (push),
    .push_addr (I_wr_addr),
    .push_data (I_wr_data),
    .pop       (do_write),
    .head_addr (head_addr),
    .head_data (head_data),
    .full      (full),
    .empty     (empty),
    .level     (O_level)
  );

  // Stage p1: registered RAM port, one cycle behind I_blanking
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state_p1    <= ST_BLANK_IDLE;
      blank_p1    <= 1'b0;
      wr_cnt_p1   <= '0;
      ram_addr_p1 <= '0;
      ram_din_p1  <= '0;
    end else begin
      blank_p1  <= I_blanking;
      wr_cnt_p1 <= do_write ? sat_inc(cnt_eff) : cnt_eff;
      if (!I_blanking) begin
        state_p1    <= ST_ACTIVE;
        ram_addr_p1 <= I_rd_addr;
      end else if (do_write) begin
        state_p1    <= ST_BLANK_WRITE;
        ram_addr_p1 <= head_addr;
        ram_din_p1  <= head_data;
      end else begin
        state_p1    <= ST_BLANK_IDLE;
      end
    end
  end

  assign O_ram_oe   = state_p1[1];
  assign O_ram_wr   = state_p1[0];
  assign O_ram_addr = ram_addr_p1;
  assign O_ram_din  = ram_din_p1;

endmodule

// File: tb/tb_vram_port_scheduler.sv
// Bench for vram_port_scheduler: two instances (unlimited and quota=2) against a queue model.
module tb_vram_port_scheduler;
  localparam int DEPTH = 4;
  localparam int NI    = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic wr_valid = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic blanking = 1'b0;
  logic [3:0] rd_addr = '0;

  logic [NI-1:0] ready, oe, wr, busy;
  logic [NI-1:0][3:0] ram_addr;
  logic [NI-1:0][7:0] ram_din;
  logic [NI-1:0][2:0] level;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;
  int wcount [NI];

  always #5 clk = ~clk;

  vram_port_scheduler #(.ADDR_W(4), .DATA_W(8), .FIFO_DEPTH(DEPTH), .MAX_WR_PER_BLANK(0)) u0 (
    .I_clk(clk), .I_rst(rst), .I_wr_valid(wr_valid), .I_wr_addr(wr_addr), .I_wr_data(wr_data),
    .O_wr_ready(ready[0]), .I_blanking(blanking), .I_rd_addr(rd_addr), .O_ram_oe(oe[0]),
    .O_ram_wr(wr[0]), .O_ram_addr(ram_addr[0]), .O_ram_din(ram_din[0]), .O_level(level[0]),
    .O_busy(busy[0]));

  vram_port_scheduler #(.ADDR_W(4), .DATA_W(8), .FIFO_DEPTH(DEPTH), .MAX_WR_PER_BLANK(2)) u1 (
    .I_clk(clk), .I_rst(rst), .I_wr_valid(wr_valid), .I_wr_addr(wr_addr), .I_wr_data(wr_data),
    .O_wr_ready(ready[1]), .I_blanking(blanking), .I_rd_addr(rd_addr), .O_ram_oe(oe[1]),
    .O_ram_wr(wr[1]), .O_ram_addr(ram_addr[1]), .O_ram_din(ram_din[1]), .O_level(level[1]),
    .O_busy(busy[1]));

  function automatic int maxw(int i);
    return (i == 0) ? 0 : 2;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of pending writes per instance plus the
  // expected registered port view.
  typedef struct packed {logic [3:0] a; logic [7:0] d;} ent_t;
  ent_t mq [NI][$];
  bit   mblank [NI];
  int   mcnt [NI];
  logic moe [NI];
  logic mwr [NI];
  logic [3:0] maddr [NI];
  logic [7:0] mdin [NI];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NI; i++) begin
        mq[i].delete();
        mblank[i] = 0; mcnt[i] = 0;
        moe[i] = 0; mwr[i] = 0; maddr[i] = '0; mdin[i] = '0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        bit acc, pop;
        int ce;
        acc = wr_valid && (mq[i].size() < DEPTH);
        ce  = (blanking && !mblank[i]) ? 0 : mcnt[i];
        pop = 0;
        if (!blanking) begin
          moe[i] = 1; mwr[i] = 0; maddr[i] = rd_addr;
        end else if (mq[i].size() > 0 && (maxw(i) == 0 || ce < maxw(i))) begin
          moe[i] = 0; mwr[i] = 1; maddr[i] = mq[i][0].a; mdin[i] = mq[i][0].d;
          pop = 1;
        end else begin
          moe[i] = 0; mwr[i] = 0;
        end
        mcnt[i]   = ce + (pop ? 1 : 0);
        mblank[i] = blanking;
        if (pop) void'(mq[i].pop_front());
        if (acc) mq[i].push_back({wr_addr, wr_data});
      end
    end
  end

  // Compare process: every negative edge once the bench has started checking.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("oe%0d", i), 32'(oe[i]), 32'(moe[i]));
        chk($sformatf("wr%0d", i), 32'(wr[i]), 32'(mwr[i]));
        chk($sformatf("addr%0d", i), 32'(ram_addr[i]), 32'(maddr[i]));
        chk($sformatf("din%0d", i), 32'(ram_din[i]), 32'(mdin[i]));
        chk($sformatf("level%0d", i), 32'(level[i]), 32'(mq[i].size()));
        chk($sformatf("busy%0d", i), 32'(busy[i]), 32'(mq[i].size() > 0));
        chk($sformatf("ready%0d", i), 32'(ready[i]), 32'(mq[i].size() < DEPTH));
        if (wr[i] === 1'b1) wcount[i]++;
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(logic [3:0] a, logic [7:0] d);
    wr_valid = 1; wr_addr = a; wr_data = d;
    tick();
    wr_valid = 0;
  endtask

  task automatic clr_counts();
    for (int i = 0; i < NI; i++) wcount[i] = 0;
  endtask

  initial begin
    int guard;
    clr_counts();
    #1 rst = 1;
    tick(3);
    chk("reset_oe", 32'(oe[0]), 32'd0);
    chk("reset_wr", 32'(wr[0]), 32'd0);
    chk("reset_ready", 32'(ready[0]), 32'd1);
    chk("reset_level", 32'(level[0]), 32'd0);
    chk("reset_addr", 32'(ram_addr[0]), 32'd0);
    chk_en = 1;
    rst = 0;

    // Active video: read address follows one cycle later
    blanking = 0;
    for (int k = 0; k < 16; k++) begin
      rd_addr = 4'(k);
      tick();
      chk("sweep_addr", 32'(ram_addr[0]), 32'(k));
      chk("sweep_oe", 32'(oe[0]), 32'd1);
    end

    // Two writes queued, drained when blanking rises
    push(4'd3, 8'hA5);
    push(4'd7, 8'h5A);
    chk("two_level", 32'(level[0]), 32'd2);
    chk("two_nowr", 32'(wr[0]), 32'd0);
    blanking = 1;
    tick();
    chk("first_wr", 32'(wr[0]), 32'd1);
    chk("first_addr", 32'(ram_addr[0]), 32'd3);
    chk("first_din", 32'(ram_din[0]), 32'hA5);
    tick();
    chk("second_addr", 32'(ram_addr[0]), 32'd7);
    chk("second_din", 32'(ram_din[0]), 32'h5A);
    tick();
    chk("idle_wr", 32'(wr[0]), 32'd0);
    chk("idle_oe", 32'(oe[0]), 32'd0);
    chk("idle_level", 32'(level[0]), 32'd0);
    blanking = 0;
    tick(2);

    // Overflow: fifth push held until a pop frees a slot
    for (int k = 0; k < 4; k++) push(4'(k + 8), 8'(8'h10 + k));
    chk("full_ready", 32'(ready[0]), 32'd0);
    chk("full_level", 32'(level[0]), 32'd4);
    clr_counts();
    wr_valid = 1; wr_addr = 4'hC; wr_data = 8'h99;
    blanking = 1;
    guard = 0;
    while (!ready[0] && guard < 10) begin
      tick();
      guard++;
    end
    chk("fifth_wait_bound", 32'(guard < 10), 32'd1);
    tick();
    wr_valid = 0;
    tick(8);
    chk("overflow_writes_u0", 32'(wcount[0]), 32'd5);
    chk("overflow_writes_u1", 32'(wcount[1]), 32'd2);
    for (int r = 0; r < 2; r++) begin
      blanking = 0; tick(2);
      blanking = 1; tick(8);
    end
    chk("drained_u1", 32'(level[1]), 32'd0);

    // Quota: 4 queued, limited instance writes 2 per interval
    blanking = 0; tick(2);
    for (int k = 0; k < 4; k++) push(4'(k), 8'(8'hC0 + k));
    clr_counts();
    blanking = 1; tick(8);
    chk("quota1_u0", 32'(wcount[0]), 32'd4);
    chk("quota1_u1", 32'(wcount[1]), 32'd2);
    blanking = 0; tick(2);
    clr_counts();
    blanking = 1; tick(8);
    chk("quota2_u0", 32'(wcount[0]), 32'd0);
    chk("quota2_u1", 32'(wcount[1]), 32'd2);

    // Blanking falls with two entries left
    blanking = 0; tick(2);
    for (int k = 0; k < 4; k++) push(4'(k + 4), 8'(8'h30 + k));
    blanking = 1; tick(2);
    blanking = 0; tick();
    chk("fall_oe", 32'(oe[0]), 32'd1);
    chk("fall_wr", 32'(wr[0]), 32'd0);
    chk("fall_level", 32'(level[0]), 32'd2);
    tick(2);
    blanking = 1; tick(8);
    chk("fall_drained", 32'(level[0]), 32'd0);

    // Asynchronous reset mid-drain
    blanking = 0; tick(2);
    for (int k = 0; k < 3; k++) push(4'(k + 1), 8'(8'h70 + k));
    blanking = 1; tick();
    rst = 1;
    #1;
    chk("rst_wr", 32'(wr[0]), 32'd0);
    chk("rst_oe", 32'(oe[0]), 32'd0);
    chk("rst_level", 32'(level[0]), 32'd0);
    chk("rst_addr", 32'(ram_addr[0]), 32'd0);
    chk("rst_din", 32'(ram_din[0]), 32'd0);
    tick(2);
    rst = 0;
    clr_counts();
    tick(5);
    chk("rst_nowr", 32'(wcount[0]), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      wr_valid = 1'($urandom_range(0, 1));
      wr_addr  = 4'($urandom);
      wr_data  = 8'($urandom);
      rd_addr  = 4'($urandom);
      if ($urandom_range(0, 7) == 0) blanking = ~blanking;
      rst = ($urandom_range(0, 599) == 0);
      tick();
    end
    rst = 0; wr_valid = 0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
